// File: rtl/switch_sequencer_if.sv
// Control, pattern-table write and switch-drive bundle for switch_sequencer.
// The slave side is the sequencer; the master side is whoever drives it.
interface switch_sequencer_if #(
  parameter int N_CH = 8,
  parameter int AW   = 4,
  parameter int DW   = 8
) ();
  logic            tick;
  logic            start;
  logic            stop;
  logic            loop;
  logic [AW-1:0]   last_idx;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [N_CH-1:0] wr_pat;
  logic [DW-1:0]   wr_dwell;
  logic            gen_load;
  logic            gen_en;
  logic [N_CH-1:0] sw_out;
  logic [AW-1:0]   step;
  logic            busy;
  logic            done;

  modport master (
    output tick, start, stop, loop, last_idx,
    output wr_en, wr_addr, wr_pat, wr_dwell,
    input  gen_load, gen_en, sw_out, step, busy, done
  );

  modport slave (
    input  tick, start, stop, loop, last_idx,
    input  wr_en, wr_addr, wr_pat, wr_dwell,
    output gen_load, gen_en, sw_out, step, busy, done
  );
endinterface

// File: rtl/switch_sequencer.sv
// Steps a table of photonic switch patterns, holding each for a
// programmable number of generator ticks, once or in a loop.
module switch_sequencer #(
  parameter int N_CH  = 8,
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic            clk,
  input logic            reset,
  switch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [N_CH-1:0] pat_mem   [DEPTH];
  logic [DW-1:0]   dwell_mem [DEPTH];
  logic [DW-1:0]   remaining;
  logic            loop_q;
  logic [AW-1:0]   last_q;
  logic [AW-1:0]   step_q;
  logic [N_CH-1:0] sw_q;
  logic            gen_load_q;
  logic            gen_en_q;
  logic            busy_q;
  logic            done_q;
  logic [AW-1:0]   nxt;
  logic [DW-1:0]   nxt_dwell;
  logic [DW-1:0]   first_dwell;

  function automatic logic [DW-1:0] eff(input logic [DW-1:0] d);
    return (d == '0) ? DW'(1) : d;
  endfunction

  // Table has no reset; contents survive it.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_q) begin
      pat_mem[bus.wr_addr]   <= bus.wr_pat;
      dwell_mem[bus.wr_addr] <= bus.wr_dwell;
    end
  end

  always_comb begin
    nxt         = (step_q == last_q) ? '0 : step_q + AW'(1);
    nxt_dwell   = eff(dwell_mem[nxt]);
    first_dwell = eff(dwell_mem[0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= '0;
      loop_q     <= 1'b0;
      last_q     <= '0;
      step_q     <= '0;
      sw_q       <= '0;
      gen_load_q <= 1'b0;
      gen_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      gen_load_q <= 1'b0;
      if (bus.stop) begin
        state     <= IDLE;
        remaining <= '0;
        step_q    <= '0;
        sw_q      <= '0;
        gen_en_q  <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (bus.start) begin
              state      <= SYNC;
              loop_q     <= bus.loop;
              last_q     <= bus.last_idx;
              step_q     <= '0;
              gen_load_q <= 1'b1;
              gen_en_q   <= 1'b1;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
            end
          end
          // A tick coincident with the restart pulse predates the
          // generator reload, so only later ticks qualify.
          SYNC: begin
            if (bus.tick && !gen_load_q) begin
              state     <= RUN;
              step_q    <= '0;
              sw_q      <= pat_mem[0];
              remaining <= first_dwell;
            end
          end
          RUN: begin
            if (bus.tick) begin
              if (remaining <= DW'(1)) begin
                if (step_q == last_q && !loop_q) begin
                  state    <= DONE;
                  sw_q     <= '0;
                  gen_en_q <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                end else begin
                  step_q    <= nxt;
                  sw_q      <= pat_mem[nxt];
                  remaining <= nxt_dwell;
                end
              end else begin
                remaining <= remaining - DW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.gen_load = gen_load_q;
  assign bus.gen_en   = gen_en_q;
  assign bus.sw_out   = sw_q;
  assign bus.step     = step_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
